// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state encoding and forwarding-select constants for pipe_hazard_ctrl
package hazard_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;
   localparam int FWD_W = 2;
   localparam logic [FWD_W-1:0] FWD_NONE = 2'd0;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority comparator choosing the nearest stage that writes src
//   dst_valid in  per-stage write enable, stage 0 = EX/MEM
//   dst_reg   in  packed per-stage destination, stage 0 in LSBs
//   src       in  operand register index read in EX
//   sel       out 0 = register file, k = stage k-1
module fwd_select
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_FWD    = 2
) (
   input  logic [NUM_FWD-1:0]            dst_valid,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] dst_reg,
   input  logic [REG_ADDR_W-1:0]         src,
   output logic [FWD_W-1:0]              sel
);
   // Scan farthest to nearest so the nearest matching stage overwrites the result.
   always_comb begin
      sel = FWD_NONE;
      for (int k = NUM_FWD - 1; k >= 0; k--)
         if (dst_valid[k] && dst_reg[k*REG_ADDR_W +: REG_ADDR_W] != '0 &&
             dst_reg[k*REG_ADDR_W +: REG_ADDR_W] == src)
            sel = FWD_W'(k + 1);
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/forwarding controller (dmem wait, branch flush, load-use stall, forwarding)
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   id_rs/id_rt/id_uses_rt  operands of the instruction in ID
//   ex_mem_read/ex_rs/ex_rt instruction in EX (ex_rt = load destination)
//   dst_valid/dst_reg       per-stage writeback info for forwarding, stage 0 = EX/MEM
//   br_taken                taken branch resolved in MEM
//   dmem_req/dmem_ack       data-memory handshake of the MEM stage
//   pc_write/ifid_write     PC and IF/ID load enables
//   idex_bubble/flush/freeze pipeline control
//   fwd_a/fwd_b             EX operand mux selects
//   mem_err                 sticky dmem timeout flag
//   stall_cnt/flush_cnt     saturating perf counters, present only with HAZARD_PERF_CNT_EN
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_FWD    = 2,
   parameter int LOAD_LAT   = 1,
   parameter int MEM_TMO    = 15,
   parameter int CNT_W      = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [REG_ADDR_W-1:0]         id_rs,
   input  logic [REG_ADDR_W-1:0]         id_rt,
   input  logic                          id_uses_rt,
   input  logic                          ex_mem_read,
   input  logic [REG_ADDR_W-1:0]         ex_rs,
   input  logic [REG_ADDR_W-1:0]         ex_rt,
   input  logic [NUM_FWD-1:0]            dst_valid,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] dst_reg,
   input  logic                          br_taken,
   input  logic                          dmem_req,
   input  logic                          dmem_ack,
   output logic                          pc_write,
   output logic                          ifid_write,
   output logic                          idex_bubble,
   output logic                          flush,
   output logic                          freeze,
   output logic [1:0]                    fwd_a,
   output logic [1:0]                    fwd_b,
   output logic                          mem_err,
   output logic [CNT_W-1:0]              stall_cnt,
   output logic [CNT_W-1:0]              flush_cnt
);
   state_e      state_q, state_d;
   logic [2:0]  ld_cnt_q, ld_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        mem_err_q, mem_err_d;
   logic        mem_stall, load_use;

   assign mem_stall = dmem_req && !dmem_ack;
   assign load_use  = ex_mem_read && ex_rt != '0 &&
                      (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));

   // ld_cnt is kept at 0 whenever the FSM is in RUN so a later MEM_WAIT exit
   // never resumes a stale load stall.
   always_comb begin
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      mem_err_d   = mem_err_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      flush       = 1'b0;
      freeze      = 1'b0;
      case (state_q)
         RUN, LD_STALL: begin
            if (mem_stall) begin
               freeze     = 1'b1;
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end else if (br_taken) begin
               flush    = 1'b1;
               state_d  = RUN;
               ld_cnt_d = '0;
            end else if (state_q == LD_STALL) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               ld_cnt_d    = ld_cnt_q - 3'd1;
               state_d     = ld_cnt_q == 3'd1 ? RUN : LD_STALL;
            end else if (load_use) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_d  = LD_STALL;
                  ld_cnt_d = 3'(LOAD_LAT - 1);
               end
            end
         end
         MEM_WAIT: begin
            freeze     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if (dmem_ack) begin
               state_d = ld_cnt_q != '0 ? LD_STALL : RUN;
            end else if (wait_cnt_q == 8'(MEM_TMO)) begin
               mem_err_d = 1'b1;
               state_d   = RUN;
               ld_cnt_d  = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q    <= RUN;
         ld_cnt_q   <= '0;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end

   assign mem_err = mem_err_q;

   fwd_select #(.REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD)) u_fwd_a (
      .dst_valid(dst_valid), .dst_reg(dst_reg), .src(ex_rs), .sel(fwd_a)
   );
   fwd_select #(.REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD)) u_fwd_b (
      .dst_valid(dst_valid), .dst_reg(dst_reg), .src(ex_rt), .sel(fwd_b)
   );

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   always_comb begin
      stall_cnt_d = (!pc_write && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   localparam int W = 5;
   localparam int NF = 3;
   localparam int CW = 4;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   localparam logic [4:0] C_RUN   = 5'b11000;
   localparam logic [4:0] C_STALL = 5'b00100;
   localparam logic [4:0] C_FLUSH = 5'b11010;
   localparam logic [4:0] C_FRZ   = 5'b00001;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [W-1:0] id_rs, id_rt, ex_rs, ex_rt;
   logic id_uses_rt, ex_mem_read, br_taken, dmem_req, dmem_ack;
   logic [NF-1:0] dst_valid;
   logic [NF*W-1:0] dst_reg;
   logic pc_write, ifid_write, idex_bubble, flush, freeze, mem_err;
   logic [1:0] fwd_a, fwd_b;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [4:0] ctl;
   int checks = 0;
   int failures = 0;

   assign ctl = {pc_write, ifid_write, idex_bubble, flush, freeze};

   always #5 clock = ~clock;

   pipe_hazard_ctrl #(.REG_ADDR_W(W), .NUM_FWD(NF), .LOAD_LAT(3), .MEM_TMO(15), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rs(ex_rs), .ex_rt(ex_rt), .dst_valid(dst_valid),
      .dst_reg(dst_reg), .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble), .flush(flush),
      .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic idle();
      id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
      ex_rs = '0; ex_rt = '0; dst_valid = '0; dst_reg = '0;
      br_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      idle();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic load_use_inputs();
      ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (ctl !== C_RUN) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RUN); end
      checks++;
      if ({fwd_a, fwd_b, mem_err} !== 5'b0) begin
         failures++; $display("FAIL reset_misc got=%b exp=%b", {fwd_a, fwd_b, mem_err}, 5'b0);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== 8'h00) begin
         failures++; $display("FAIL reset_cnt got=%h exp=00", {stall_cnt, flush_cnt});
      end
   endtask

   task automatic test_forwarding();
      logic [NF-1:0]   v [6] = '{3'b011, 3'b011, 3'b110, 3'b111, 3'b111, 3'b111};
      logic [NF*W-1:0] r [6] = '{{5'd0, 5'd3, 5'd3}, {5'd0, 5'd3, 5'd0}, {5'd3, 5'd7, 5'd3},
                                 {5'd0, 5'd0, 5'd0}, {5'd1, 5'd2, 5'd4}, {5'd9, 5'd9, 5'd9}};
      logic [W-1:0]    s [6] = '{5'd3, 5'd3, 5'd3, 5'd0, 5'd6, 5'd9};
      logic [W-1:0]    t [6] = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd8, 5'd9};
      logic [1:0]      ea[6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
      logic [1:0]      eb[6] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         dst_valid = v[i]; dst_reg = r[i]; ex_rs = s[i]; ex_rt = t[i];
         #1;
         checks++;
         if ({fwd_a, fwd_b} !== {ea[i], eb[i]}) begin
            failures++;
            $display("FAIL fwd%0d got a=%0d b=%0d exp a=%0d b=%0d", i, fwd_a, fwd_b, ea[i], eb[i]);
         end
      end
      @(negedge clock);
      idle();
   endtask

   task automatic test_load_use();
      logic [4:0] exp_seq [4] = '{C_STALL, C_STALL, C_STALL, C_RUN};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         idle();
         if (i == 0) load_use_inputs();
         #1;
         checks++;
         if (ctl !== exp_seq[i]) begin
            failures++; $display("FAIL load_use_c%0d got=%b exp=%b", i, ctl, exp_seq[i]);
         end
      end
      checks++;
      if (stall_cnt !== (PERF ? 4'd3 : 4'd0)) begin
         failures++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, PERF ? 3 : 0);
      end
      @(negedge clock);
      ex_mem_read = 1'b1; ex_rt = 5'd6; id_rt = 5'd6; id_uses_rt = 1'b0;
      #1;
      checks++;
      if (ctl !== C_RUN) begin failures++; $display("FAIL rt_unused got=%b exp=%b", ctl, C_RUN); end
      id_uses_rt = 1'b1;
      #1;
      checks++;
      if (ctl !== C_STALL) begin failures++; $display("FAIL rt_used got=%b exp=%b", ctl, C_STALL); end
      @(negedge clock);
      idle();
      @(negedge clock);
      @(negedge clock);
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #1;
      checks++;
      if (ctl !== C_RUN) begin failures++; $display("FAIL r0_load got=%b exp=%b", ctl, C_RUN); end
      @(negedge clock);
      idle();
   endtask

   task automatic test_branch();
      do_reset();
      @(negedge clock);
      load_use_inputs(); br_taken = 1'b1;
      #1;
      checks++;
      if (ctl !== C_FLUSH) begin failures++; $display("FAIL br_lu got=%b exp=%b", ctl, C_FLUSH); end
      @(negedge clock);
      idle();
      #1;
      checks++;
      if (ctl !== C_RUN) begin failures++; $display("FAIL br_after got=%b exp=%b", ctl, C_RUN); end
      load_use_inputs();
      #1;
      checks++;
      if (ctl !== C_STALL) begin failures++; $display("FAIL br_ld got=%b exp=%b", ctl, C_STALL); end
      @(negedge clock);
      idle(); br_taken = 1'b1;
      #1;
      checks++;
      if (ctl !== C_FLUSH) begin failures++; $display("FAIL br_abort got=%b exp=%b", ctl, C_FLUSH); end
      @(negedge clock);
      idle();
      #1;
      checks++;
      if (ctl !== C_RUN) begin failures++; $display("FAIL br_abort_run got=%b exp=%b", ctl, C_RUN); end
      checks++;
      if ({stall_cnt, flush_cnt} !== (PERF ? {4'd1, 4'd2} : 8'h00)) begin
         failures++;
         $display("FAIL br_cnt got=%h exp=%h", {stall_cnt, flush_cnt}, PERF ? 8'h12 : 8'h00);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         idle();
         dmem_req = i < 4;
         dmem_ack = i == 3;
         br_taken = i == 1;
         #1;
         checks++;
         if (ctl !== (i < 4 ? C_FRZ : C_RUN)) begin
            failures++; $display("FAIL mem_wait_c%0d got=%b exp=%b", i, ctl, i < 4 ? C_FRZ : C_RUN);
         end
      end
      checks++;
      if ({mem_err, stall_cnt, flush_cnt} !== {1'b0, PERF ? 4'd4 : 4'd0, 4'd0}) begin
         failures++;
         $display("FAIL mem_wait_end got err=%b stall=%0d flush=%0d exp err=0 stall=%0d flush=0",
                  mem_err, stall_cnt, flush_cnt, PERF ? 4 : 0);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_seq [6] = '{C_STALL, C_FRZ, C_FRZ, C_STALL, C_STALL, C_RUN};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         idle();
         if (i == 0) load_use_inputs();
         dmem_req = i == 1 || i == 2;
         dmem_ack = i == 2;
         #1;
         checks++;
         if (ctl !== exp_seq[i]) begin
            failures++; $display("FAIL b2b_c%0d got=%b exp=%b", i, ctl, exp_seq[i]);
         end
      end
      checks++;
      if (stall_cnt !== (PERF ? 4'd5 : 4'd0)) begin
         failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", stall_cnt, PERF ? 5 : 0);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         @(negedge clock);
         dmem_req = 1'b1;
         #1;
         checks++;
         if ({ctl, mem_err} !== {C_FRZ, 1'b0}) begin
            failures++; $display("FAIL tmo_c%0d got=%b err=%b exp=%b err=0", i, ctl, mem_err, C_FRZ);
         end
      end
      @(negedge clock);
      dmem_req = 1'b0;
      #1;
      checks++;
      if ({ctl, mem_err} !== {C_RUN, 1'b1}) begin
         failures++; $display("FAIL tmo_end got=%b err=%b exp=%b err=1", ctl, mem_err, C_RUN);
      end
      checks++;
      if (stall_cnt !== (PERF ? 4'd15 : 4'd0)) begin
         failures++; $display("FAIL tmo_sat got=%0d exp=%0d", stall_cnt, PERF ? 15 : 0);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({mem_err, stall_cnt} !== 5'b0) begin
         failures++; $display("FAIL tmo_async_rst got err=%b stall=%0d exp err=0 stall=0", mem_err, stall_cnt);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      @(negedge clock);
      load_use_inputs();
      @(negedge clock);
      idle();
      #1;
      checks++;
      if (ctl !== C_STALL) begin failures++; $display("FAIL mid_pre got=%b exp=%b", ctl, C_STALL); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({ctl, stall_cnt, flush_cnt} !== {C_RUN, 8'h00}) begin
         failures++;
         $display("FAIL mid_rst got=%b stall=%0d flush=%0d exp=%b 0 0", ctl, stall_cnt, flush_cnt, C_RUN);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (ctl !== C_RUN) begin failures++; $display("FAIL mid_post got=%b exp=%b", ctl, C_RUN); end
   endtask

   initial begin
      idle();
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_back_to_back();
      test_timeout();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
